// File: rtl/jmp_pkg.sv
// Shared definitions for the jump/branch/call sequencer.
// Condition codes, jump modes, the sequencer state type and the default return-stack depth.
package jmp_pkg;

    // Condition codes, taken from jmpins[2:0]
    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_NZ     = 3'd2;
    localparam logic [2:0] COND_L      = 3'd3;
    localparam logic [2:0] COND_LE     = 3'd4;
    localparam logic [2:0] COND_G      = 3'd5;
    localparam logic [2:0] COND_GE     = 3'd6;
    localparam logic [2:0] COND_C      = 3'd7;

    // Jump modes, taken from jmpins[4:3]
    localparam logic [1:0] MODE_ABS  = 2'd0;
    localparam logic [1:0] MODE_REL  = 2'd1;
    localparam logic [1:0] MODE_CALL = 2'd2;
    localparam logic [1:0] MODE_RET  = 2'd3;

    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [1:0] {IDLE, FETCH, EVAL, LOAD} state_t;

endpackage

// File: rtl/jmp_ras.sv
// Return-address stack: a small LIFO.
// A push when full and a pop when empty are both ignored; the sequencer checks full/empty first.
module jmp_ras
    import jmp_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = STACK_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);

    localparam int SP_W = $clog2(DEPTH + 1);

    logic [SP_W-1:0]           sp_q, sp_d;
    logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;

    assign full  = (sp_q == SP_W'(DEPTH));
    assign empty = (sp_q == '0);

    // Top of stack is the entry just below the stack pointer
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (SP_W'(i + 1) == sp_q) top = mem_q[i];
    end

    // Next stack pointer and storage contents
    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++)
                if (SP_W'(i) == sp_q) mem_d[i] = din;
            sp_d = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    // Stack registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sp_q  <= '0;
            mem_q <= '0;
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/jmp_seq.sv
// Jump / branch / call-return sequencer for the 8-bit CPU.
// Latches the opcode, PC and flags, fetches the operand byte, evaluates the
// condition and issues a one-cycle PC load. CALL/RET use a return-address
// stack only when JMP_CALL_STACK_EN is defined; otherwise they complete as not taken.
module jmp_seq
    import jmp_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      jmpins,
    input  logic [PC_W-1:0] pcin,
    input  logic [7:0]      databus,
    input  logic            mem_ready,
    input  logic            zin,
    input  logic            oin,
    input  logic            cin,
    input  logic            sin,
    output logic            busy,
    output logic            mem_rd,
    output logic            pcoe,
    output logic [PC_W-1:0] pcout,
    output logic            taken,
    output logic            done,
    output logic            stack_err
);

    function automatic logic cond_f(input logic [2:0] cc, input logic z, o, c, s);
        case (cc)
            COND_ALWAYS: cond_f = 1'b1;
            COND_Z:      cond_f = z;
            COND_NZ:     cond_f = !z;
            COND_L:      cond_f = (s != o);
            COND_LE:     cond_f = z || (s != o);
            COND_G:      cond_f = !z && (s == o);
            COND_GE:     cond_f = (s == o);
            default:     cond_f = c;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [2:0]      cc_q, cc_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            z_q, z_d, o_q, o_d, c_q, c_d, s_q, s_d;
    logic [7:0]      opnd_q, opnd_d;
    logic [PC_W-1:0] res_q, res_d;
    logic            tkn_q, tkn_d;

    logic            cond_ok;
    logic [PC_W-1:0] fall_pc, rel_pc, abs_pc;
    logic signed [7:0] opnd_s;

    // Opcode bits [7:5] carry no meaning for this unit
    logic unused_ins;
    assign unused_ins = ^jmpins[7:5];

    assign cond_ok = cond_f(cc_q, z_q, o_q, c_q, s_q);
    assign opnd_s  = opnd_q;
    assign abs_pc  = PC_W'(opnd_q);
    assign rel_pc  = pc_q + PC_W'(2) + PC_W'(opnd_s);
    assign fall_pc = (mode_q == MODE_RET) ? pc_q + PC_W'(1) : pc_q + PC_W'(2);

`ifdef JMP_CALL_STACK_EN
    logic            serr_q, serr_d;
    logic            push_q, push_d, pop_q, pop_d;
    logic            ras_full, ras_empty;
    logic [PC_W-1:0] ras_top;

    // Push/pop are applied in the LOAD cycle, decided one cycle earlier in EVAL
    jmp_ras #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (state_q == LOAD && push_q),
        .pop   (state_q == LOAD && pop_q),
        .din   (pc_q + PC_W'(2)),
        .full  (ras_full),
        .empty (ras_empty),
        .top   (ras_top)
    );

    assign stack_err = (state_q == LOAD) && serr_q;
`else
    localparam int unused_depth = STACK_DEPTH;
    assign stack_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (jmpins[4:3] == MODE_RET) ? EVAL : FETCH;
            FETCH:   if (mem_ready) state_d = EVAL;
            EVAL:    state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs; pcout is forced to zero outside LOAD
    always_comb begin
        busy   = (state_q != IDLE);
        mem_rd = (state_q == FETCH);
        pcoe   = (state_q == LOAD);
        done   = (state_q == LOAD);
        taken  = (state_q == LOAD) && tkn_q;
        pcout  = (state_q == LOAD) ? res_q : '0;
    end

    // Datapath: capture request, operand, then the resolved next PC
    always_comb begin
        mode_d = mode_q;
        cc_d   = cc_q;
        pc_d   = pc_q;
        z_d    = z_q;
        o_d    = o_q;
        c_d    = c_q;
        s_d    = s_q;
        opnd_d = opnd_q;
        res_d  = res_q;
        tkn_d  = tkn_q;
`ifdef JMP_CALL_STACK_EN
        serr_d = serr_q;
        push_d = push_q;
        pop_d  = pop_q;
`endif
        if (state_q == IDLE && start) begin
            mode_d = jmpins[4:3];
            cc_d   = jmpins[2:0];
            pc_d   = pcin;
            z_d    = zin;
            o_d    = oin;
            c_d    = cin;
            s_d    = sin;
        end
        if (state_q == FETCH && mem_ready) opnd_d = databus;
        if (state_q == EVAL) begin
            tkn_d = cond_ok;
            res_d = cond_ok ? abs_pc : fall_pc;
`ifdef JMP_CALL_STACK_EN
            serr_d = 1'b0;
            push_d = 1'b0;
            pop_d  = 1'b0;
`endif
            case (mode_q)
                MODE_ABS: ;
                MODE_REL: res_d = cond_ok ? rel_pc : fall_pc;
`ifdef JMP_CALL_STACK_EN
                MODE_CALL: begin
                    if (cond_ok && ras_full) begin
                        tkn_d  = 1'b0;
                        serr_d = 1'b1;
                        res_d  = fall_pc;
                    end else if (cond_ok) begin
                        push_d = 1'b1;
                    end
                end
                default: begin
                    if (cond_ok && ras_empty) begin
                        tkn_d  = 1'b0;
                        serr_d = 1'b1;
                        res_d  = fall_pc;
                    end else if (cond_ok) begin
                        pop_d = 1'b1;
                        res_d = ras_top;
                    end
                end
`else
                default: begin
                    tkn_d = 1'b0;
                    res_d = fall_pc;
                end
`endif
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q <= '0;
            cc_q   <= '0;
            pc_q   <= '0;
            z_q    <= 1'b0;
            o_q    <= 1'b0;
            c_q    <= 1'b0;
            s_q    <= 1'b0;
            opnd_q <= '0;
            res_q  <= '0;
            tkn_q  <= 1'b0;
`ifdef JMP_CALL_STACK_EN
            serr_q <= 1'b0;
            push_q <= 1'b0;
            pop_q  <= 1'b0;
`endif
        end else begin
            mode_q <= mode_d;
            cc_q   <= cc_d;
            pc_q   <= pc_d;
            z_q    <= z_d;
            o_q    <= o_d;
            c_q    <= c_d;
            s_q    <= s_d;
            opnd_q <= opnd_d;
            res_q  <= res_d;
            tkn_q  <= tkn_d;
`ifdef JMP_CALL_STACK_EN
            serr_q <= serr_d;
            push_q <= push_d;
            pop_q  <= pop_d;
`endif
        end
    end

endmodule

// File: tb/tb_jmp_seq.sv
// Directed testbench for jmp_seq; the stack tests are built only with JMP_CALL_STACK_EN.
module tb_jmp_seq;

    logic       clk = 1'b0;
    logic       reset, start, mem_ready, zin, oin, cin, sin;
    logic [7:0] jmpins, pcin, databus;
    logic       busy, mem_rd, pcoe, taken, done, stack_err;
    logic [7:0] pcout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jmp_seq #(.PC_W(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .jmpins(jmpins), .pcin(pcin),
        .databus(databus), .mem_ready(mem_ready), .zin(zin), .oin(oin), .cin(cin),
        .sin(sin), .busy(busy), .mem_rd(mem_rd), .pcoe(pcoe), .pcout(pcout),
        .taken(taken), .done(done), .stack_err(stack_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete jump; fl = {z,o,c,s}; wt = cycles mem_ready is held low in FETCH
    task automatic do_jmp(input string tag, input logic [7:0] ins, input logic [7:0] pc,
                          input logic [3:0] fl, input logic [7:0] op, input int wt,
                          input logic [7:0] epc, input logic etk, input logic eserr);
        start = 1'b1;
        jmpins = ins;
        pcin = pc;
        {zin, oin, cin, sin} = fl;
        step();
        start = 1'b0;
        jmpins = 8'h00;
        pcin = 8'h00;
        {zin, oin, cin, sin} = ~fl;
        if (ins[4:3] != 2'b11) begin
            for (int i = 0; i < wt; i++) begin
                chk({tag, ".wait_rd"}, mem_rd, 1);
                step();
            end
            mem_ready = 1'b1;
            databus = op;
            chk({tag, ".mem_rd"}, mem_rd, 1);
            step();
            mem_ready = 1'b0;
            databus = 8'h00;
        end
        chk({tag, ".eval_pcoe"}, pcoe, 0);
        step();
        chk({tag, ".pcoe"}, pcoe, 1);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".pcout"}, pcout, epc);
        chk({tag, ".taken"}, taken, etk);
        chk({tag, ".serr"}, stack_err, eserr);
        step();
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        int npcoe;
        reset = 1'b0;
        start = 1'b0;
        mem_ready = 1'b0;
        jmpins = 8'h00;
        pcin = 8'h00;
        databus = 8'h00;
        {zin, oin, cin, sin} = 4'h0;
        step();
        step();
        chk("rst.busy", busy, 0);
        chk("rst.mem_rd", mem_rd, 0);
        chk("rst.pcoe", pcoe, 0);
        chk("rst.taken", taken, 0);
        chk("rst.done", done, 0);
        chk("rst.serr", stack_err, 0);
        chk("rst.pcout", pcout, 0);
        reset = 1'b1;
        step();

        do_jmp("abs",      8'h00, 8'h10, 4'b0000, 8'h80, 0, 8'h80, 1, 0);
        do_jmp("je_nt",    8'h01, 8'h20, 4'b0000, 8'h55, 3, 8'h22, 0, 0);
        do_jmp("je_t",     8'h01, 8'h20, 4'b1000, 8'h44, 0, 8'h44, 1, 0);
        do_jmp("rel_wrap", 8'h08, 8'hFC, 4'b0000, 8'h05, 0, 8'h03, 1, 0);
        do_jmp("rel_neg",  8'h08, 8'h10, 4'b0000, 8'hF0, 1, 8'h02, 1, 0);
        do_jmp("jl",       8'h03, 8'h30, 4'b0001, 8'h33, 0, 8'h33, 1, 0);
        do_jmp("jg",       8'h05, 8'h30, 4'b0101, 8'h66, 0, 8'h66, 1, 0);
        do_jmp("jge_nt",   8'h06, 8'h40, 4'b0001, 8'h77, 0, 8'h42, 0, 0);
        do_jmp("jle_z",    8'h04, 8'h40, 4'b1000, 8'h11, 0, 8'h11, 1, 0);
        do_jmp("jnz_nt",   8'h02, 8'h50, 4'b1000, 8'h99, 0, 8'h52, 0, 0);
        do_jmp("jc",       8'h07, 8'h50, 4'b0010, 8'hA5, 0, 8'hA5, 1, 0);
        do_jmp("hi_bits",  8'hE0, 8'h58, 4'b0000, 8'h3C, 0, 8'h3C, 1, 0);
        do_jmp("rel_nt",   8'h0F, 8'h60, 4'b0000, 8'h10, 0, 8'h62, 0, 0);

        // Second start while busy must be ignored
        start = 1'b1;
        jmpins = 8'h00;
        pcin = 8'h10;
        step();
        jmpins = 8'h08;
        pcin = 8'h90;
        mem_ready = 1'b1;
        databus = 8'h21;
        step();
        start = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("busy_st.pcoe", pcoe, 1);
        chk("busy_st.pcout", pcout, 8'h21);
        npcoe = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pcoe) npcoe++;
        end
        chk("busy_st.extra", npcoe, 0);

        // Reset while in FETCH aborts without a PC load
        start = 1'b1;
        jmpins = 8'h00;
        pcin = 8'h70;
        step();
        start = 1'b0;
        chk("rstf.fetch", mem_rd, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rstf.busy", busy, 0);
        mem_ready = 1'b1;
        databus = 8'hEE;
        npcoe = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (pcoe) npcoe++;
        end
        chk("rstf.nopcoe", npcoe, 0);
        mem_ready = 1'b0;
        do_jmp("after_rst", 8'h00, 8'h70, 4'b0000, 8'hC4, 0, 8'hC4, 1, 0);

`ifdef JMP_CALL_STACK_EN
        do_jmp("call0", 8'h10, 8'h00, 4'b0000, 8'hA0, 0, 8'hA0, 1, 0);
        do_jmp("call1", 8'h10, 8'h10, 4'b0000, 8'hA1, 0, 8'hA1, 1, 0);
        do_jmp("call2", 8'h10, 8'h20, 4'b0000, 8'hA2, 0, 8'hA2, 1, 0);
        do_jmp("call3", 8'h10, 8'h30, 4'b0000, 8'hA3, 0, 8'hA3, 1, 0);
        do_jmp("call_full", 8'h10, 8'h40, 4'b0000, 8'hA4, 0, 8'h42, 0, 1);
        do_jmp("ret_nt", 8'h19, 8'h80, 4'b0000, 8'h00, 0, 8'h81, 0, 0);
        do_jmp("ret0", 8'h18, 8'h80, 4'b0000, 8'h00, 0, 8'h32, 1, 0);
        do_jmp("ret1", 8'h18, 8'h80, 4'b0000, 8'h00, 0, 8'h22, 1, 0);
        do_jmp("ret2", 8'h18, 8'h80, 4'b0000, 8'h00, 0, 8'h12, 1, 0);
        do_jmp("ret3", 8'h18, 8'h80, 4'b0000, 8'h00, 0, 8'h02, 1, 0);
        do_jmp("ret_empty", 8'h18, 8'h80, 4'b0000, 8'h00, 0, 8'h81, 0, 1);
`else
        do_jmp("call_off", 8'h10, 8'h70, 4'b0000, 8'h99, 0, 8'h72, 0, 0);
        do_jmp("ret_off",  8'h18, 8'h60, 4'b0000, 8'h00, 0, 8'h61, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
